// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, default widths and reset PC,
// plus the saturating-add helper used by the optional FETCH_PERF_EN counters.
package cpu_pkg;

  localparam int unsigned FETCH_ADDR_W   = 8;
  localparam int unsigned FETCH_INSTR_W  = 32;
  localparam logic [7:0]  FETCH_RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'b0, inc};
    return s[16] ? '1 : s[15:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/gnt/rvalid handshake between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_stage_perf_counters.sv
// Saturating 16-bit fetch statistics; only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counters
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        inc_fetched,
  input  logic        inc_halt,
  input  logic [1:0]  inc_squash,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_halt,
  output logic [15:0] perf_squash
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perf_fetched <= '0;
      perf_halt    <= '0;
      perf_squash  <= '0;
    end else begin
      perf_fetched <= sat_add16(perf_fetched, {1'b0, inc_fetched});
      perf_halt    <= sat_add16(perf_halt, {1'b0, inc_halt});
      perf_squash  <= sat_add16(perf_squash, inc_squash);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: one outstanding imem transaction, registered decode slot,
// redirect squashing. Define FETCH_PERF_EN to add the perf_* counter outputs.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               halt_fetch,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  fetch_stage_if.master      imem,
  output logic               fvalid,
  output logic [INSTR_W-1:0] finstr,
  output logic [ADDR_W-1:0]  fpc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_halt,
  output logic [15:0]        perf_squash
`endif
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               fvalid_q, fvalid_d;
  logic [INSTR_W-1:0] finstr_q;
  logic [ADDR_W-1:0]  fpc_q;
  logic               capture;
  logic               slot_free;

  assign slot_free = !fvalid_q || !halt_fetch;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      fvalid_q <= 1'b0;
      finstr_q <= '0;
      fpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fvalid_q <= fvalid_d;
      if (capture) begin
        finstr_q <= imem.imem_rdata;
        fpc_q    <= pc_q;
      end
    end
  end

  // Redirect wins over gnt, rvalid and halt in every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (!halt_fetch && slot_free) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = IDLE;
        end else if (imem.imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem.imem_rvalid ? IDLE : DRAIN;
        end else if (imem.imem_rvalid) begin
          capture = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = redirect_pc;
        if (imem.imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    fvalid_d = fvalid_q;
    if (redirect) begin
      fvalid_d = 1'b0;
    end else if (capture) begin
      fvalid_d = 1'b1;
    end else if (fvalid_q && !halt_fetch) begin
      fvalid_d = 1'b0;
    end
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign fvalid         = fvalid_q;
  assign finstr         = finstr_q;
  assign fpc            = fpc_q;

`ifdef FETCH_PERF_EN
  logic       inc_fetched;
  logic [1:0] inc_squash;

  // A redirect can discard both the slot and the in-flight response in one cycle.
  assign inc_fetched = fvalid_q && !halt_fetch && !redirect;
  assign inc_squash  = {1'b0, redirect && fvalid_q} + {1'b0, redirect && (state_q == WAIT)};

  fetch_perf_counters u_perf (
    .clk          (clk),
    .n_rst        (n_rst),
    .inc_fetched  (inc_fetched),
    .inc_halt     (halt_fetch),
    .inc_squash   (inc_squash),
    .perf_fetched (perf_fetched),
    .perf_halt    (perf_halt),
    .perf_squash  (perf_squash)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural memory.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          halt_fetch;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          fvalid;
  logic [IW-1:0] finstr;
  logic [AW-1:0] fpc;
`ifdef FETCH_PERF_EN
  logic [15:0]   perf_fetched, perf_halt, perf_squash;
`endif

  fetch_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) imem ();

  fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .halt_fetch   (halt_fetch),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem         (imem),
    .fvalid       (fvalid),
    .finstr       (finstr),
    .fpc          (fpc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_halt    (perf_halt),
    .perf_squash  (perf_squash)
`endif
  );

  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural slot, next fetch PC, one in-flight record.
  logic          m_valid;
  logic [AW-1:0] m_fpc;
  logic [IW-1:0] m_instr;
  logic [AW-1:0] m_pc;
  logic          inf_valid, inf_sq;
  logic [AW-1:0] inf_addr;
  // Behavioural memory.
  logic          mem_busy;
  int unsigned   mem_cnt;
  logic [AW-1:0] mem_addr;
  logic          force_dead;
  int unsigned   stall_run;
  int unsigned   n_fetched, n_halt, n_squash;

  task automatic cycle(input logic h, input logic rd, input logic [AW-1:0] rpc,
                       input int unsigned gnt_pct, input int unsigned lat);
    logic          rv, g, req, cap;
    logic [IW-1:0] rdat;
    logic [AW-1:0] addr;
    rv = 1'b0;
    rdat = '0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        rv = 1'b1;
        rdat = force_dead ? 32'h0000_DEAD : {24'h0, 8'(mem_addr + 8'hA0)};
        mem_busy = 1'b0;
        force_dead = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    g = !mem_busy && !rv && ($urandom_range(99) < gnt_pct);
    halt_fetch = h;
    redirect = rd;
    redirect_pc = rpc;
    imem.imem_gnt = g;
    imem.imem_rvalid = rv;
    imem.imem_rdata = rv ? rdat : $urandom;
    #1;
    req = imem.imem_req;
    addr = imem.imem_addr;
    if (!h && !rd && !req && !inf_valid && !mem_busy) stall_run++;
    else stall_run = 0;

    @(posedge clk);
    #1;
    cap = rv && inf_valid && !inf_sq && !rd;
    if (h) n_halt++;
    if (m_valid && !h && !rd) n_fetched++;
    if (rd) n_squash += (m_valid ? 1 : 0) + ((inf_valid && !inf_sq) ? 1 : 0);
    if (rd) m_valid = 1'b0;
    else if (cap) begin
      m_valid = 1'b1;
      m_fpc = inf_addr;
      m_instr = rdat;
    end else if (m_valid && !h) m_valid = 1'b0;
    if (rd) m_pc = rpc;
    else if (cap) m_pc = inf_addr + 8'd1;
    if (rv) inf_valid = 1'b0;
    if (rd) inf_sq = 1'b1;
    if (req && g && !rd) begin
      inf_valid = 1'b1;
      inf_sq = 1'b0;
      inf_addr = addr;
      mem_busy = 1'b1;
      mem_addr = addr;
      mem_cnt = lat - 1;
    end

    check("fvalid", 64'(fvalid), 64'(m_valid));
    if (m_valid) begin
      check("fpc", 64'(fpc), 64'(m_fpc));
      check("finstr", 64'(finstr), 64'(m_instr));
    end
    if (imem.imem_req) begin
      check("req_addr", 64'(imem.imem_addr), 64'(m_pc));
      check("req_outstanding", 64'(inf_valid | mem_busy), 64'(0));
    end
    check("stall", 64'(stall_run > 3), 64'(0));
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    halt_fetch = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;
    #1;
    check("rst_fvalid", 64'(fvalid), 64'(0));
    check("rst_finstr", 64'(finstr), 64'(0));
    check("rst_fpc", 64'(fpc), 64'(0));
    check("rst_req", 64'(imem.imem_req), 64'(0));
    check("rst_addr", 64'(imem.imem_addr), 64'(8'h00));
    m_valid = 1'b0;
    m_fpc = '0;
    m_instr = '0;
    m_pc = 8'h00;
    inf_valid = 1'b0;
    inf_sq = 1'b0;
    stall_run = 0;
    n_fetched = 0;
    n_halt = 0;
    n_squash = 0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic run_until_req(input int unsigned budget, input string tag);
    int unsigned i;
    i = 0;
    while (!imem.imem_req && i < budget) begin
      cycle(1'b0, 1'b0, '0, 0, 1);
      i++;
    end
    check(tag, 64'(imem.imem_req), 64'(1));
  endtask

  task automatic run_until_fvalid(input int unsigned budget, input string tag);
    int unsigned i;
    i = 0;
    while (!fvalid && i < budget) begin
      cycle(1'b0, 1'b0, '0, 100, 1);
      i++;
    end
    check(tag, 64'(fvalid), 64'(1));
  endtask

  initial begin
    int unsigned seen;
    mem_busy = 1'b0;
    mem_cnt = 0;
    mem_addr = '0;
    force_dead = 1'b0;
    do_reset();

    // Free run, 1-cycle memory: one instruction every 3rd cycle, fpc 0,1,2.
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0, '0, 100, 1);
      if (fvalid) begin
        check("run_fpc", 64'(fpc), 64'(seen));
        check("run_finstr", 64'(finstr), 64'(8'hA0 + seen));
        seen++;
      end
    end
    check("run_count", 64'(seen), 64'(3));

    // Halt with fpc=3 presented.
    for (int i = 0; i < 12 && !(fvalid && fpc == 8'd3); i++) cycle(1'b0, 1'b0, '0, 100, 1);
    check("reach_fpc3", 64'({fvalid, fpc}), 64'({1'b1, 8'd3}));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, '0, 100, 1);
      check("halt_noreq", 64'(imem.imem_req), 64'(0));
      check("halt_fpc", 64'({fvalid, fpc}), 64'({1'b1, 8'd3}));
    end
    run_until_req(6, "resume_req");
    check("resume_addr", 64'(imem.imem_addr), 64'(8'd4));

    // Redirect in WAIT, stale 0xDEAD response two cycles later is dropped.
    cycle(1'b0, 1'b0, '0, 100, 3);
    force_dead = 1'b1;
    cycle(1'b0, 1'b1, 8'h40, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, '0, 0, 1);
      check("drain_fvalid", 64'(fvalid), 64'(0));
    end
    run_until_req(6, "drain_req");
    check("drain_addr", 64'(imem.imem_addr), 64'(8'h40));

    // Redirect coincident with rvalid, then redirect while halted with a valid slot.
    cycle(1'b0, 1'b0, '0, 100, 1);
    cycle(1'b0, 1'b1, 8'h10, 0, 1);
    check("coinc_fvalid", 64'(fvalid), 64'(0));
    run_until_fvalid(10, "coinc_refetch");
    check("coinc_fpc", 64'(fpc), 64'(8'h10));
    cycle(1'b1, 1'b0, '0, 0, 1);
    cycle(1'b1, 1'b1, 8'h10, 0, 1);
    check("halt_squash", 64'(fvalid), 64'(0));
    run_until_fvalid(10, "halt_refetch");
    check("halt_squash_fpc", 64'(fpc), 64'(8'h10));

    // PC wrap 0xFF -> 0x00.
    cycle(1'b0, 1'b1, 8'hFF, 0, 1);
    for (int i = 0; i < 10 && !(fvalid && fpc == 8'hFF); i++) cycle(1'b0, 1'b0, '0, 100, 1);
    check("wrap_fpc", 64'({fvalid, fpc}), 64'({1'b1, 8'hFF}));
    run_until_req(6, "wrap_req");
    check("wrap_addr", 64'(imem.imem_addr), 64'(8'h00));

    // Reset while waiting; the late response lands in IDLE and is ignored.
    cycle(1'b0, 1'b0, '0, 100, 2);
    check("pre_rst_busy", 64'(mem_busy), 64'(1));
    do_reset();
    mem_cnt = 0;
    cycle(1'b0, 1'b0, '0, 0, 1);
    check("late_rv_fvalid", 64'(fvalid), 64'(0));
    check("post_rst_req", 64'(imem.imem_req), 64'(1));
    check("post_rst_addr", 64'(imem.imem_addr), 64'(8'h00));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 25, $urandom_range(99) < 8, 8'($urandom),
            60, $urandom_range(3, 1));
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 100, 1);

`ifdef FETCH_PERF_EN
    check("perf_fetched", 64'(perf_fetched), 64'(n_fetched));
    check("perf_halt", 64'(perf_halt), 64'(n_halt));
    check("perf_squash", 64'(perf_squash), 64'(n_squash));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
